// File: rtl/spi_cfg_pkg.sv
// Shared types and helpers for the configurable SPI master.
package spi_cfg_pkg;

  typedef enum logic [1:0] {IDLE, FRONT, XFER, BACK} spi_state_t;

  // Width of the slave-select index; a single slave still gets a 1-bit port.
  function automatic int unsigned ss_width(input int unsigned num_ss);
    return (num_ss <= 1) ? 1 : $clog2(num_ss);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: porch load, free-running count while active, registered SCLK and
// strobes flagging the clk edge on which SCLK will lead or trail.
module spi_sclk_gen #(
  parameter int unsigned DIV_W = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic run_i,
  input  logic run_nxt_i,
  input  logic cpol_nxt_i,
  output logic sclk_o,
  output logic lead_o,
  output logic trail_o
);

  localparam logic [DIV_W-1:0] DivLoad   = {2'b11, {(DIV_W-2){1'b0}}};
  localparam logic [DIV_W-1:0] DivLast   = {DIV_W{1'b1}};
  localparam logic [DIV_W-1:0] DivHalfM1 = {1'b0, {(DIV_W-1){1'b1}}};

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;

  always_comb begin
    div_d = div_q;
    if (load_i) begin
      div_d = DivLoad;
    end else if (run_i) begin
      div_d = div_q + DIV_W'(1);
    end
    // Raw clock is the inverted divider MSB, forced low outside the active window.
    sclk_d  = cpol_nxt_i ^ (run_nxt_i & ~div_d[DIV_W-1]);
    lead_o  = run_i & (div_q == DivLast);
    trail_o = run_i & (div_q == DivHalfM1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_mstr_cfg.sv
// Parametrised SPI master with per-transaction CPOL/CPHA and multiple slave selects.
// Shift register, bit counter and FSM live here; SCLK timing comes from spi_sclk_gen.
module spi_mstr_cfg
  import spi_cfg_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DIV_W  = 6,
  parameter int unsigned NUM_SS = 1,
  parameter int unsigned SS_W   = ss_width(NUM_SS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [DATA_W-1:0] cmd,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic [NUM_SS-1:0] SS_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned      CNT_W   = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DATA_W);

  spi_state_t state_q, state_d;

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic              sample_q, sample_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;

  logic accept, lead, trail, last, shift, run_nxt;

  assign accept  = wrt & ~busy;
  assign last    = lead & (cnt_q == CntLast);
  assign run_nxt = (state_d == FRONT) || (state_d == XFER);

  spi_sclk_gen #(
    .DIV_W (DIV_W)
  ) u_sclk_gen (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (accept),
    .run_i      (busy),
    .run_nxt_i  (run_nxt),
    .cpol_nxt_i (cpol_d),
    .sclk_o     (SCLK),
    .lead_o     (lead),
    .trail_o    (trail)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = FRONT;
      FRONT:   if (lead) state_d = XFER;
      XFER:    if (last) state_d = BACK;
      BACK:    state_d = accept ? FRONT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // BACK lasts exactly one cycle, so it doubles as the done pulse.
  always_comb begin
    busy = (state_q == FRONT) || (state_q == XFER);
    done = (state_q == BACK);
  end

  always_comb begin
    shreg_d  = shreg_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    ss_n_d   = ss_n_q;
    sample_d = sample_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    // With cpha=1 the first leading edge only launches data, nothing is shifted in yet.
    shift    = cpha_q ? (lead & (cnt_q != '0)) : trail;
    if (accept) begin
      shreg_d = cmd;
      cnt_d   = '0;
      cpol_d  = cpol;
      cpha_d  = cpha;
      for (int unsigned i = 0; i < NUM_SS; i++) begin
        ss_n_d[i] = (ss_sel != SS_W'(i));
      end
    end else begin
      if (lead) cnt_d = cnt_q + CNT_W'(1);
      if (cpha_q ? trail : lead) sample_d = MISO;
      if (shift) shreg_d = {shreg_q[DATA_W-2:0], sample_q};
      if (last) begin
        rd_d   = shreg_d;
        ss_n_d = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      ss_n_q   <= '1;
      sample_q <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      ss_n_q   <= ss_n_d;
      sample_q <= sample_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
    end
  end

  assign MOSI    = shreg_q[DATA_W-1];
  assign SS_n    = ss_n_q;
  assign rd_data = rd_q;

endmodule
